// File: rtl/pixel_stream_tb_gen.sv
// ---------------------------------------------------------------------------
// pixel_stream_tb_gen
//
// Stimulus source for pixel-path benches. Emits framed, multi-lane
// incrementing pixel data with a valid/stall handshake, optional idle
// insertion (none / periodic / LFSR), inter-frame gaps and an end-of-frame
// marker. A stalled beat is held stable until it is accepted.
//
// Optional feature macro: PIXEL_TB_GEN_CHKSUM_EN
//   When defined, adds output ochk, the per-frame lane checksum.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   en         in   start pulse/level, only looked at in IDLE
//   istall     in   downstream stall; beat accepted when oval & !istall
//   odat       out  NUM_CH lanes, lane k at [k*DAT_WIDTH +: DAT_WIDTH]
//   oval       out  beat valid
//   olast      out  last beat of frame (qualified by oval)
//   done       out  all NUM_FRAMES frames accepted (sticky until rst)
//   frame_cnt  out  frames fully accepted, saturating at 16'hFFFF
//   ochk       out  (macro only) mod-2^DAT_WIDTH sum of all lanes of the
//                   last completed frame
// ---------------------------------------------------------------------------
module pixel_stream_tb_gen #(
  parameter int          DAT_WIDTH  = 8,
  parameter int          NUM_CH     = 4,
  parameter int          FRAME_LEN  = 64,
  parameter int          NUM_FRAMES = 0,
  parameter int          GAP_CYCLES = 4,
  parameter int          MODE       = 0,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          istall,
  output logic [NUM_CH*DAT_WIDTH-1:0]   odat,
  output logic                          oval,
  output logic                          olast,
  output logic                          done,
  output logic [15:0]                   frame_cnt
`ifdef PIXEL_TB_GEN_CHKSUM_EN
  ,
  output logic [DAT_WIDTH-1:0]          ochk
`endif
);

  localparam int BW = (FRAME_LEN  > 1) ? $clog2(FRAME_LEN)  : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int PW = NUM_CH * DAT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Lane k of a beat carries base+k, wrapping at the lane width.
  function automatic logic [PW-1:0] pack_lanes(input logic [DAT_WIDTH-1:0] base);
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      v[k*DAT_WIDTH +: DAT_WIDTH] = base + DAT_WIDTH'(k);
    end
    return v;
  endfunction

  // Frame counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [PW-1:0]          r_odat;
  logic                   r_oval;
  logic                   r_olast;
  logic                   r_done;
  logic [15:0]            r_frame_cnt;
  logic [DAT_WIDTH-1:0]   r_base;
  logic [BW-1:0]          r_beat;
  logic [GW-1:0]          r_gap;
  logic [1:0]             r_free;
  logic [15:0]            r_lfsr;

  logic                   w_pause;
  logic                   w_acc;
  logic                   w_last_acc;
  logic                   w_fin;
  logic                   w_gap_end;
  logic                   w_launch;
  logic [DAT_WIDTH-1:0]   w_base_nxt;
  logic [BW-1:0]          w_beat_nxt;
  logic                   w_olast_new;

  assign odat      = r_odat;
  assign oval      = r_oval;
  assign olast     = r_olast;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;

  // Handshake decode. oval is only ever high in RUN, so istall has no
  // effect in the other states.
  assign w_acc      = r_oval & ~istall;
  assign w_last_acc = w_acc & r_olast;
  assign w_fin      = (NUM_FRAMES != 0) &&
                      (({1'b0, r_frame_cnt} + 17'd1) == 17'(NUM_FRAMES));
  assign w_gap_end  = (r_gap == GW'(GAP_CYCLES - 1));

  always_comb begin
    w_pause = 1'b0;
    if (MODE == 1) begin
      w_pause = (r_free == 2'b11);
    end else if (MODE == 2) begin
      w_pause = r_lfsr[0] & r_lfsr[1];
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last_acc) begin
          if (w_fin)                w_state_nxt = S_DONE;
          else if (GAP_CYCLES > 0)  w_state_nxt = S_GAP;
          else                      w_state_nxt = S_RUN;
        end
      end
      S_GAP: begin
        if (w_gap_end) w_state_nxt = S_RUN;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic (launch decision and next beat contents)
  // -------------------------------------------------------------------------
  // The edge that leaves IDLE or GAP also launches the first beat, so the
  // first oval follows en by one cycle and a gap is exactly GAP_CYCLES long.
  always_comb begin
    w_launch = 1'b0;
    case (r_state)
      S_IDLE:  w_launch = en & ~w_pause;
      S_RUN:   w_launch = (w_state_nxt == S_RUN) & (~r_oval | ~istall) & ~w_pause;
      S_GAP:   w_launch = w_gap_end & ~w_pause;
      default: w_launch = 1'b0;
    endcase

    // Base and beat index as they stand after this edge's acceptance, so a
    // beat launched on the same edge already sees the advanced values.
    w_base_nxt = w_acc ? (r_base + DAT_WIDTH'(NUM_CH)) : r_base;
    if (w_acc) begin
      w_beat_nxt = r_olast ? '0 : (r_beat + BW'(1));
    end else begin
      w_beat_nxt = r_beat;
    end
    w_olast_new = (w_beat_nxt == BW'(FRAME_LEN - 1));
  end

  // -------------------------------------------------------------------------
  // Registered beat, counters and pause sources
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_odat      <= '0;
      r_oval      <= 1'b0;
      r_olast     <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
      r_base      <= '0;
      r_beat      <= '0;
      r_gap       <= '0;
      r_free      <= '0;
      r_lfsr      <= SEED;
    end else begin
      r_base <= w_base_nxt;
      r_beat <= w_beat_nxt;
      r_free <= r_free + 2'd1;
      r_lfsr <= lfsr_step(r_lfsr);
      r_done <= (w_state_nxt == S_DONE);

      // A pending beat is replaced only on launch and retired only on
      // acceptance; while stalled it holds, whatever pause says.
      if (w_launch) begin
        r_odat  <= pack_lanes(w_base_nxt);
        r_oval  <= 1'b1;
        r_olast <= w_olast_new;
      end else if (w_acc) begin
        r_oval  <= 1'b0;
        r_olast <= 1'b0;
      end

      if (w_last_acc) begin
        r_frame_cnt <= sat_inc16(r_frame_cnt);
      end

      if (r_state == S_GAP) begin
        r_gap <= r_gap + GW'(1);
      end else begin
        r_gap <= '0;
      end
    end
  end

`ifdef PIXEL_TB_GEN_CHKSUM_EN
  // -------------------------------------------------------------------------
  // Per-frame checksum: running sum of accepted lanes, published when the
  // olast beat is accepted.
  // -------------------------------------------------------------------------
  function automatic logic [DAT_WIDTH-1:0] sum_lanes(input logic [PW-1:0] d);
    logic [DAT_WIDTH-1:0] s;
    s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      s = s + d[k*DAT_WIDTH +: DAT_WIDTH];
    end
    return s;
  endfunction

  logic [DAT_WIDTH-1:0] r_chk_acc;
  logic [DAT_WIDTH-1:0] r_chk;
  logic [DAT_WIDTH-1:0] w_chk_beat;

  assign w_chk_beat = sum_lanes(r_odat);
  assign ochk       = r_chk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk_acc <= '0;
      r_chk     <= '0;
    end else if (w_last_acc) begin
      r_chk     <= r_chk_acc + w_chk_beat;
      r_chk_acc <= '0;
    end else if (w_acc) begin
      r_chk_acc <= r_chk_acc + w_chk_beat;
    end
  end
`endif

endmodule

// File: doc/pixel_stream_tb_gen.md
Name: pixel_stream_tb_gen

Overview:
Parametrised, synthesizable-style stimulus source for pixel-path testbenches. It emits framed, multi-lane incrementing pixel data with a valid/stall handshake, selectable idle-insertion modes, inter-frame gaps and an end-of-frame marker. It drives the input side of pixel concat/packing blocks under test. Unlike a simple pause generator, it holds a stalled beat stable rather than dropping it.

Parameters:
DAT_WIDTH, 8, bits per lane (pixel)
NUM_CH, 4, lanes per beat, packed on odat
FRAME_LEN, 64, beats per frame (>=1)
NUM_FRAMES, 0, frames to emit; 0 = unlimited
GAP_CYCLES, 4, idle cycles after each frame (0 = back-to-back)
MODE, 0, 0 = no pauses; 1 = periodic pause; 2 = LFSR pseudo-random pause
SEED, 16'hACE1, LFSR reset value for MODE 2 (must be non-zero)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  start pulse/level, sampled in IDLE only
istall  in  1  downstream stall; beat accepted when oval & !istall
odat  out  NUM_CH*DAT_WIDTH  lane k at bits [k*DAT_WIDTH +: DAT_WIDTH]
oval  out  1  beat valid
olast  out  1  last beat of frame, qualified by oval
done  out  1  all NUM_FRAMES frames accepted
frame_cnt  out  16  frames fully accepted, saturating at 16'hFFFF

Behaviour:
- Reset values: odat=0, oval=0, olast=0, done=0, frame_cnt=0. Internal data base=0, beat counter=0, gap counter=0, free-running counter=0, LFSR=SEED, state=IDLE.
- All outputs are registered.
- Lane values: beat n carries lane k = base+k (mod 2^DAT_WIDTH). On each accepted beat, base += NUM_CH, wrapping mod 2^DAT_WIDTH. base continues across frames and is cleared only by rst.
- pause:
  - MODE 0: always 0.
  - MODE 1: free-running counter bits [1:0]==2'b11, i.e. 1 idle cycle in 4.
  - MODE 2: lfsr[0]&lfsr[1]. LFSR is 16-bit Fibonacci, taps 16,14,13,11, stepped every cycle after reset.
- Launch condition: a new beat is loaded when state is RUN, (!oval | !istall), and !pause.
- Hold rule: while oval=1 and istall=1, odat/oval/olast hold unchanged. pause never retracts a pending beat.
- If a beat is accepted and the launch condition is false, oval drops to 0 at the next edge.
- FSM:
  - IDLE: en=1 -> RUN, and the first beat launches on the same edge if not paused. First oval is therefore 1 cycle after en is sampled.
  - RUN: the beat counter counts accepted beats. The beat with index FRAME_LEN-1 is launched with olast=1. On acceptance of the olast beat, frame_cnt++ and the beat counter clears. Next state is then:
    - DONE, if NUM_FRAMES!=0 and frame_cnt+1==NUM_FRAMES;
    - GAP, if GAP_CYCLES>0;
    - otherwise stay in RUN, with the next beat launchable on the same edge (true back-to-back).
  - GAP: oval=0 for exactly GAP_CYCLES cycles, then RUN.
  - DONE: done=1 and oval=0, held until rst; en ignored.
- FRAME_LEN=1: every beat has olast=1.
- rst mid-frame: everything returns to reset values on the next edge, including a pending stalled beat, which is discarded. Restart requires en.
- istall is ignored when oval=0. istall in IDLE, GAP or DONE has no effect.

Optional Feature:
PIXEL_TB_GEN_CHKSUM_EN:
- Defined: adds output ochk [DAT_WIDTH-1:0]. It is the mod-2^DAT_WIDTH sum of all lanes of all accepted beats in the current frame, including the olast beat. It updates on the edge of the olast acceptance and holds until the next olast acceptance (reset 0). This gives the checker a per-frame golden value.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- DAT_WIDTH=8, NUM_CH=4, FRAME_LEN=2, NUM_FRAMES=2, GAP_CYCLES=0, MODE 0, istall=0; en pulse -> 4 consecutive beats odat=32'h03020100, 07060504, 0B0A0908, 0F0E0D0C; olast on beats 2 and 4; done=1 and frame_cnt=2 one cycle after beat 4.
- Same config; istall=1 for 3 cycles while beat 32'h07060504 is valid -> odat/oval/olast held stable for all 3 cycles; beat accepted once, with no duplicate or skipped value.
- GAP_CYCLES=3, NUM_FRAMES=0 -> after each olast acceptance oval=0 for exactly 3 cycles, then the next frame continues base; frame_cnt increments per frame.
- MODE 1, istall=0 -> oval low exactly 1 cycle in every 4 during RUN; data strictly incrementing by NUM_CH per accepted beat, wrapping 0xFC->0x00 at DAT_WIDTH=8.
- MODE 2 with SEED=16'hACE1 vs a reference LFSR model -> idle cycles match lfsr[0]&lfsr[1] exactly; rst asserted mid-frame -> next cycle oval=0, odat=0, frame_cnt=0, and en restarts at lane value 0.
- With PIXEL_TB_GEN_CHKSUM_EN defined, FRAME_LEN=2, NUM_CH=4, DAT_WIDTH=8 -> after frame 1, ochk=8'h1C (0+..+7); after frame 2, ochk=8'h5C (8+..+15).
